// File: rtl/seq_pkg.sv
// Shared types and helpers for the multi-state sequencer and its prescaler.
package seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ACTIVE = 2'd1,
    SEQ_GUARD  = 2'd2
  } seq_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Tick generator: counts 0..PRESCALE-1 and flags the last count; clear holds it at zero.
module seq_prescaler
  import seq_pkg::*;
#(
  parameter int PRESCALE = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = idx_width(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/multi_state_sequencer.sv
// NUM_STATES-step sequencer with programmable per-state dwell in prescaled ticks.
// Define SEQ_GUARD_EN to insert GUARD_TICKS dead-time ticks between states.
module multi_state_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STATES    = 4,
  parameter int PRESCALE      = 40,
  parameter int DWELL_W       = 16,
  parameter int DEFAULT_DWELL = 1,
  parameter int GUARD_TICKS   = 1,
  localparam int IDX_W        = idx_width(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  single_shot,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [DWELL_W-1:0]    cfg_data,
  output logic [IDX_W-1:0]      state,
  output logic [NUM_STATES-1:0] state_onehot,
  output logic                  state_strobe,
  output logic                  cycle_done,
  output logic                  busy
);

  seq_state_e         fsm;
  logic [DWELL_W-1:0] dwell [NUM_STATES];
  logic [DWELL_W-1:0] dwell_cnt;
  logic               ss_latched;
  logic               done_lock;
  logic               tick;
  logic               last_idx;
  logic [IDX_W-1:0]   next_idx;

`ifdef SEQ_GUARD_EN
  localparam int GUARD_W = idx_width(GUARD_TICKS);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_TICKS - 1);
  logic [GUARD_W-1:0] guard_cnt;
`else
  localparam int unused_guard_ticks = GUARD_TICKS;
`endif

  seq_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(fsm == SEQ_IDLE),
    .tick (tick)
  );

  function automatic logic [NUM_STATES-1:0] decode(input logic [IDX_W-1:0] i);
    return NUM_STATES'(1) << i;
  endfunction

  assign last_idx = (state == IDX_W'(NUM_STATES - 1));
  assign next_idx = last_idx ? '0 : state + 1'b1;

  // NOTE: the dwell file is a small register array, so it is reset explicitly to a known default.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        dwell[i] <= DWELL_W'(DEFAULT_DWELL);
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_STATES)) begin
      dwell[cfg_addr] <= cfg_data;
    end
  end

  // done_lock keeps a finished single-shot run idle until run is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm          <= SEQ_IDLE;
      state        <= '0;
      state_onehot <= '0;
      state_strobe <= 1'b0;
      cycle_done   <= 1'b0;
      busy         <= 1'b0;
      dwell_cnt    <= '0;
      ss_latched   <= 1'b0;
      done_lock    <= 1'b0;
`ifdef SEQ_GUARD_EN
      guard_cnt    <= '0;
`endif
    end else begin
      state_strobe <= 1'b0;
      cycle_done   <= 1'b0;
      if (!run) begin
        fsm          <= SEQ_IDLE;
        state        <= '0;
        state_onehot <= '0;
        busy         <= 1'b0;
        done_lock    <= 1'b0;
      end else begin
        case (fsm)
          SEQ_IDLE: begin
            if (!done_lock) begin
              fsm          <= SEQ_ACTIVE;
              state        <= '0;
              state_onehot <= decode('0);
              state_strobe <= 1'b1;
              busy         <= 1'b1;
              dwell_cnt    <= dwell[0];
              ss_latched   <= single_shot;
            end
          end
          SEQ_ACTIVE: begin
            if (tick) begin
              if (dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end else begin
                if (last_idx) cycle_done <= 1'b1;
                if (last_idx && ss_latched) begin
                  fsm          <= SEQ_IDLE;
                  state        <= '0;
                  state_onehot <= '0;
                  busy         <= 1'b0;
                  done_lock    <= 1'b1;
                end else begin
`ifdef SEQ_GUARD_EN
                  fsm          <= SEQ_GUARD;
                  state_onehot <= '0;
                  guard_cnt    <= GUARD_LAST;
`else
                  state        <= next_idx;
                  state_onehot <= decode(next_idx);
                  state_strobe <= 1'b1;
                  dwell_cnt    <= dwell[next_idx];
`endif
                end
              end
            end
          end
`ifdef SEQ_GUARD_EN
          SEQ_GUARD: begin
            if (tick) begin
              if (guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
              end else begin
                fsm          <= SEQ_ACTIVE;
                state        <= next_idx;
                state_onehot <= decode(next_idx);
                state_strobe <= 1'b1;
                dwell_cnt    <= dwell[next_idx];
              end
            end
          end
`endif
          default: begin
            fsm          <= SEQ_IDLE;
            state        <= '0;
            state_onehot <= '0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/multi_state_sequencer.md
# multi_state_sequencer

Parametrised successor to the fixed four-state timing sequencer. It steps through NUM_STATES states with a programmable dwell per state, measured in prescaled ticks. It drives registered one-hot state lines into the pulse-timing fabric, and its run control, single-shot mode and cycle-done flag support pump/probe timing sequences.

## Interface
- NUM_STATES, 4, number of sequencer states (2..16)
- PRESCALE, 40, clk cycles per tick (≥1)
- DWELL_W, 16, dwell register width
- DEFAULT_DWELL, 1, reset value of every dwell register
- GUARD_TICKS, 1, dead-time ticks between states (used only with SEQ_GUARD_EN; ≥1)
- clk  in  1  system clock; the single clock domain
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = sequence runs, 0 = return to idle
- single_shot  in  1  sampled on entry from IDLE; 1 = stop after last state
- cfg_we  in  1  dwell register write strobe
- cfg_addr  in  IDX_W  dwell register index
- cfg_data  in  DWELL_W  dwell value, in ticks minus one
- state  out  IDX_W  current state index
- state_onehot  out  NUM_STATES  decoded state lines
- state_strobe  out  1  one-cycle pulse on every state entry
- cycle_done  out  1  one-cycle pulse when the last state completes
- busy  out  1  high whenever not in IDLE

IDX_W = max(1, $clog2(NUM_STATES)).

## Operation
- FSM states: IDLE and ACTIVE, plus GUARD when SEQ_GUARD_EN is defined.
- Prescaler: counts 0..PRESCALE-1 while busy. Tick is asserted when count = PRESCALE-1. The prescaler is held at 0 in IDLE.
- IDLE → ACTIVE when run=1:
  - idx=0, single_shot is latched, dwell_cnt ← dwell[0], state_strobe=1.
- ACTIVE, on each tick:
  - if dwell_cnt≠0, dwell_cnt decrements;
  - else the state ends. If idx≠NUM_STATES-1, advance to idx+1, load dwell_cnt ← dwell[idx+1], assert state_strobe.
  - If idx=NUM_STATES-1, assert cycle_done. Latched single_shot → IDLE. Otherwise wrap to idx 0 and assert state_strobe.
- Each state therefore lasts (dwell+1) ticks.
- run=0 in any state → IDLE on the next edge. idx=0, outputs low, no cycle_done.
- Dwell writes:
  - When cfg_we=1 and cfg_addr<NUM_STATES, dwell[cfg_addr] ← cfg_data. Out-of-range writes are ignored.
  - A write takes effect at the next entry into that state. The running dwell_cnt is never modified.
- state_onehot = 1<<idx in ACTIVE and all zero in IDLE/GUARD. state holds idx in all states (0 in IDLE).
- Simultaneous events:
  - run=0 with a state-ending tick: IDLE wins, no strobes.
  - reset overrides everything.

## Timing
- All outputs are registered. Reset values: state=0, state_onehot=0, state_strobe=0, cycle_done=0, busy=0. All dwell registers = DEFAULT_DWELL.
- run sampled high at edge N: busy, state_onehot[0] and state_strobe are high after edge N.
- State duration is exactly (dwell+1)·PRESCALE clk cycles (guard excluded). Full cycle = Σ(dwell_i+1)·PRESCALE.
- cycle_done and the state 0 strobe are asserted on the same edge when wrapping.
- run low at edge M: all outputs low after edge M.

## Configuration
- SEQ_GUARD_EN defined: after each state ends (including wrap, but not the final state of a single-shot run), the FSM enters GUARD for GUARD_TICKS ticks with state_onehot=0 and state holding the outgoing index.
  - cycle_done is asserted on entry to GUARD after the last state.
  - state_strobe is asserted on entry to the next ACTIVE state.
- SEQ_GUARD_EN undefined: GUARD logic is absent and state transitions are back-to-back, as described above.

## Structure
- Shared package `seq_pkg`: FSM state enum (SEQ_IDLE, SEQ_ACTIVE, SEQ_GUARD), width helper function for IDX_W.
- Sub-module `seq_prescaler`: a generalised tick generator with a clear input and a PRESCALE parameter. It is instantiated once. The dwell register file and FSM stay in the top level.

## Test plan
NUM_STATES=4 and PRESCALE=4 unless stated.
- Reset: assert reset for 10 cycles with run=1 → all outputs 0 and busy=0 during reset. Read-back behaviour shows all dwell=1.
- Cyclic run, default dwell=1: run=1 → each onehot bit is high for 8 clk in order 0,1,2,3,0. cycle_done pulses every 32 clk, coincident with the state 0 strobe.
- Single-shot: single_shot=1, dwell={0,2,0,1} → states last 4,12,4,8 clk. One cycle_done, then busy=0 and the FSM stays idle while run remains 1.
- Mid-run write: write dwell[2]=3 while in state 2 → the current state 2 keeps its old length, and the next state 2 lasts 16 clk. A write to cfg_addr=5 changes nothing.
- Abort: drop run in the middle of state 1 → all outputs are 0 after the next edge with no cycle_done. Re-raising run restarts at state 0.
- SEQ_GUARD_EN, GUARD_TICKS=1, dwell=0: the pattern is onehot 4 clk, zeros 4 clk, repeating. cycle_done is asserted at GUARD entry after state 3.
